// File: rtl/timer_pkg.sv
// Shared types and constants for the tick-driven one-shot timer.
package timer_pkg;

  localparam int unsigned WidthDefault = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_counter.sv
// Loadable, enable-gated down-counter that saturates at zero and flags cnt==1.
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_one_o
);

  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o = (cnt_q == CntOne);

endmodule

// File: rtl/timer.sv
// One-shot timer: counts Value qualified ticks, then pulses expired for one clk cycle.
module timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             Reset_Sync,
  input  logic [WIDTH-1:0] Value,
  input  logic             oneHz_enable,
  input  logic             start_timer,
  output logic             expired
);

  timer_state_e state_q;
  logic         expired_q;
  logic         cnt_is_one;
  logic         cnt_dec;

  // A tick in the start cycle is ignored; counting begins on the following edge.
  assign cnt_dec = (state_q == StRun) && oneHz_enable && !start_timer;

  timer_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk_i      (clk),
    .rst_i      (Reset_Sync),
    .load_i     (start_timer),
    .load_val_i (Value),
    .dec_i      (cnt_dec),
    .is_one_o   (cnt_is_one)
  );

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q   <= StIdle;
      expired_q <= 1'b0;
    end else if (start_timer) begin
      if (Value == '0) begin
        state_q   <= StDone;
        expired_q <= 1'b1;
      end else begin
        state_q   <= StRun;
        expired_q <= 1'b0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (oneHz_enable && cnt_is_one) begin
            state_q   <= StDone;
            expired_q <= 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          expired_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          expired_q <= 1'b0;
        end
      endcase
    end
  end

  assign expired = expired_q;

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: hand-computed expected expired values per clock cycle.
module tb_timer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         Reset_Sync;
  logic [W-1:0] Value;
  logic         oneHz_enable;
  logic         start_timer;
  logic         expired;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  timer #(
    .WIDTH(W)
  ) dut (
    .clk          (clk),
    .Reset_Sync   (Reset_Sync),
    .Value        (Value),
    .oneHz_enable (oneHz_enable),
    .start_timer  (start_timer),
    .expired      (expired)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic exp);
    vectors++;
    assert (expired === exp)
    else begin
      miscompares++;
      $error("FAIL %s: expired observed=%b expected=%b", tag, expired, exp);
    end
  endtask

  initial begin
    Reset_Sync   = 1'b1;
    Value        = 4'd3;
    oneHz_enable = 1'b1;
    start_timer  = 1'b1;

    // Reset overrides a simultaneous start and tick.
    cycle(); chk("reset_0", 1'b0);
    cycle(); chk("reset_1", 1'b0);
    Reset_Sync  = 1'b0;
    start_timer = 1'b0;
    cycle(); chk("idle_tick", 1'b0);

    // Value=6, ticks every cycle, tick in start cycle not counted.
    Value = 4'd6; start_timer = 1'b1; oneHz_enable = 1'b1;
    cycle(); chk("v6_start", 1'b0);
    start_timer = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cycle(); chk($sformatf("v6_tick%0d", i), 1'b0);
    end
    cycle(); chk("v6_expire", 1'b1);
    cycle(); chk("v6_after", 1'b0);
    cycle(); chk("v6_idle", 1'b0);

    // Value=3, ticks every other cycle.
    Value = 4'd3; start_timer = 1'b1; oneHz_enable = 1'b0;
    cycle();
    start_timer = 1'b0;
    oneHz_enable = 1'b1; cycle(); chk("v3_tick1", 1'b0);
    oneHz_enable = 1'b0; cycle(); chk("v3_gap1", 1'b0);
    oneHz_enable = 1'b1; cycle(); chk("v3_tick2", 1'b0);
    oneHz_enable = 1'b0; cycle(); chk("v3_gap2", 1'b0);
    oneHz_enable = 1'b1; cycle(); chk("v3_expire", 1'b1);
    oneHz_enable = 1'b0; cycle(); chk("v3_after", 1'b0);

    // Value=0 expires immediately.
    Value = 4'd0; start_timer = 1'b1;
    cycle(); chk("v0_expire", 1'b1);
    start_timer = 1'b0;
    cycle(); chk("v0_after", 1'b0);

    // Value=5 restarted after 2 ticks with Value=2.
    Value = 4'd5; start_timer = 1'b1; oneHz_enable = 1'b1;
    cycle();
    start_timer = 1'b0;
    cycle(); chk("rst5_tick1", 1'b0);
    cycle(); chk("rst5_tick2", 1'b0);
    Value = 4'd2; start_timer = 1'b1;
    cycle(); chk("restart2", 1'b0);
    start_timer = 1'b0;
    cycle(); chk("r2_tick1", 1'b0);
    cycle(); chk("r2_expire", 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(); chk($sformatf("r2_quiet%0d", i), 1'b0);
    end

    // Reset one tick before expiry cancels the count.
    Value = 4'd3; start_timer = 1'b1;
    cycle();
    start_timer = 1'b0;
    cycle(); chk("cx_tick1", 1'b0);
    cycle(); chk("cx_tick2", 1'b0);
    Reset_Sync = 1'b1;
    cycle(); chk("cx_reset", 1'b0);
    Reset_Sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(); chk($sformatf("cx_quiet%0d", i), 1'b0);
    end

    // Start during DONE: pulse still visible, then recount.
    Value = 4'd1; start_timer = 1'b1;
    cycle();
    start_timer = 1'b0;
    cycle(); chk("d_expire", 1'b1);
    Value = 4'd2; start_timer = 1'b1;
    #1; chk("d_no_comb", 1'b1);
    cycle(); chk("d_restart", 1'b0);
    start_timer = 1'b0;
    cycle(); chk("d_tick1", 1'b0);
    cycle(); chk("d_expire2", 1'b1);
    cycle(); chk("d_after", 1'b0);

    // Reset in DONE clears the pulse.
    Value = 4'd0; start_timer = 1'b1;
    cycle(); chk("rd_expire", 1'b1);
    start_timer = 1'b0; Reset_Sync = 1'b1;
    cycle(); chk("rd_reset", 1'b0);
    Reset_Sync = 1'b0;
    cycle(); chk("rd_quiet0", 1'b0);
    cycle(); chk("rd_quiet1", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
